// File: rtl/uart_cmd_engine_pkg.sv
// rtl/uart_cmd_engine_pkg.sv - shared types and constants for the UART command engine
package uart_cmd_engine_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [7:0] ASCII_X = 8'h58;
  localparam logic [7:0] ASCII_Q = 8'h3F;
  localparam logic [7:0] ASCII_1 = 8'h31;
  localparam logic [7:0] ASCII_2 = 8'h32;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_B = 8'h42;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_DONE = 2'd2,
    TX_GAP       = 2'd3
  } txState_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_cmd_engine_resp_fifo.sv
// rtl/uart_cmd_engine_resp_fifo.sv - response byte queue between decode/button paths and the TX FSM
module uart_resp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          pushData,
  input  logic                       pop,
  output logic [DATA_W-1:0]          popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              doWrite;
  logic              doRead;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  // A pop on a full queue frees the slot being written, so both may proceed
  assign doWrite = push & (~full | pop);
  assign doRead  = pop & ~empty;
  assign popData = mem[rdPtr];

  // Storage array; contents are don't-care until written so it carries no reset
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= pushData;
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doRead})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_engine.sv
// rtl/uart_cmd_engine.sv - decodes UART command bytes and transmits queued responses
module uart_cmd_engine
  import uart_cmd_engine_pkg::*;
#(
  parameter int                         DATA_W         = DEFAULT_DATA_W,
  parameter int                         NUM_CMDS       = 2,
  parameter logic [NUM_CMDS*DATA_W-1:0] CMD_TABLE      = {ASCII_B, ASCII_A},
  parameter logic [NUM_CMDS*DATA_W-1:0] RESP_TABLE     = {ASCII_2, ASCII_1},
  parameter logic [DATA_W-1:0]          UNK_BYTE       = ASCII_X,
  parameter logic [DATA_W-1:0]          NAK_BYTE       = ASCII_Q,
  parameter int                         FIFO_DEPTH     = 4,
  parameter int                         GAP_CYCLES     = 16,
  parameter int                         TIMEOUT_CYCLES = 4096,
  parameter int                         ERR_W          = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_valid,
  input  logic [DATA_W-1:0]             rx_data,
  input  logic                          rx_parity_err,
  input  logic                          btn_valid,
  input  logic [DATA_W-1:0]             btn_data,
  input  logic                          clr_flags,
  output logic                          tx_start,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_done,
  output logic [NUM_CMDS+1:0]           led,
  output logic [ERR_W-1:0]              err_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          tx_timeout
);

  localparam int CNT_W = $clog2(maxInt(TIMEOUT_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam txState_e AFTER_TX = (GAP_CYCLES == 0) ? TX_IDLE : TX_GAP;

  txState_e            txState;
  logic [CNT_W-1:0]    cnt;

  logic                decHit;
  logic [DATA_W-1:0]   decResp;
  logic [NUM_CMDS-1:0] decOneHot;
  logic                decErr;

  logic                pendValid;
  logic [DATA_W-1:0]   pendData;
  logic [NUM_CMDS:0]   ledBits;

  logic                pushReq;
  logic [DATA_W-1:0]   pushData;
  logic                fifoPush;
  logic                fifoPop;
  logic [DATA_W-1:0]   fifoHead;
  logic                fifoFull;
  logic                fifoEmpty;
  logic                dropEvt;

  logic [1:0]          errInc;
  logic [ERR_W:0]      errSum;
  logic [ERR_W-1:0]    errNext;

  // Table lookup: scan high-to-low so the lowest matching index wins; parity error overrides
  always_comb begin
    decHit    = 1'b0;
    decResp   = UNK_BYTE;
    decOneHot = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (CMD_TABLE[i*DATA_W +: DATA_W] == rx_data) begin
        decHit       = 1'b1;
        decResp      = RESP_TABLE[i*DATA_W +: DATA_W];
        decOneHot    = '0;
        decOneHot[i] = 1'b1;
      end
    end
    if (rx_parity_err) begin
      decHit    = 1'b0;
      decResp   = NAK_BYTE;
      decOneHot = '0;
    end
  end

  assign decErr = rx_valid & ~decHit;

  // Button bytes take the single push slot; a decoded response waits behind them
  assign pushReq  = btn_valid | pendValid;
  assign pushData = btn_valid ? btn_data : pendData;
  assign fifoPop  = (txState == TX_IDLE) & ~fifoEmpty;
  assign dropEvt  = pushReq & fifoFull & ~fifoPop;
  assign fifoPush = pushReq & ~dropEvt;

  assign errInc  = {1'b0, decErr} + {1'b0, dropEvt};
  assign errSum  = {1'b0, err_count} + (ERR_W+1)'(errInc);
  assign errNext = errSum[ERR_W] ? '1 : errSum[ERR_W-1:0];

  assign led = {(txState == TX_IDLE) & fifoEmpty, ledBits};

  uart_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifoPush),
    .pushData (pushData),
    .pop      (fifoPop),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (fifo_level)
  );

  // Decode stage: latch the response and refresh the hit/error LEDs on each received byte.
  // A new byte arriving while a held response still waits replaces it; UART byte spacing
  // makes that unreachable in practice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendValid <= 1'b0;
      pendData  <= '0;
      ledBits   <= '1;
    end else begin
      if (rx_valid) begin
        pendValid <= 1'b1;
        pendData  <= decResp;
        ledBits   <= {~decHit, decOneHot};
      end else if (pendValid && !btn_valid) begin
        pendValid <= 1'b0;
      end
    end
  end

  // Sticky overflow and saturating error count; clr_flags beats any same-cycle event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else if (clr_flags) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      err_count <= errNext;
      if (dropEvt) overflow <= 1'b1;
    end
  end

  // TX FSM: pop a byte, pulse tx_start, wait for tx_done or give up, then observe the gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState    <= TX_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      cnt        <= '0;
      tx_timeout <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (clr_flags) tx_timeout <= 1'b0;
      case (txState)
        TX_IDLE: begin
          if (!fifoEmpty) begin
            tx_data  <= fifoHead;
            tx_start <= 1'b1;
            txState  <= TX_START;
          end
        end
        TX_START: begin
          cnt     <= '0;
          txState <= TX_WAIT_DONE;
        end
        TX_WAIT_DONE: begin
          if (tx_done) begin
            cnt     <= '0;
            txState <= AFTER_TX;
          end else if (cnt == TIMEOUT_LIM) begin
            cnt     <= '0;
            txState <= AFTER_TX;
            if (!clr_flags) tx_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_GAP: begin
          if (cnt == GAP_LAST) txState <= TX_IDLE;
          else                 cnt     <= cnt + 1'b1;
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

endmodule
